// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax datapath.
// Holds the default score width, the row-stage FSM state type and a
// saturating signed subtract reused by the normalisation stage.
package softmax_pkg;

   localparam int SM_D_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // a - b evaluated one bit wider, then clamped back into SM_D_W bits.
   // A mismatch between the two top bits of the wide result means overflow.
   function automatic logic signed [SM_D_W-1:0] sat_sub(
      input logic signed [SM_D_W-1:0] a,
      input logic signed [SM_D_W-1:0] b
   );
      logic signed [SM_D_W:0] diff;
      diff = {a[SM_D_W-1], a} - {b[SM_D_W-1], b};
      if (diff[SM_D_W] != diff[SM_D_W-1]) begin
         sat_sub = diff[SM_D_W] ? {1'b1, {(SM_D_W-1){1'b0}}}
                                : {1'b0, {(SM_D_W-1){1'b1}}};
      end else begin
         sat_sub = diff[SM_D_W-1:0];
      end
   endfunction

endpackage

// File: rtl/softmax_row_buf.sv
// Row buffer: simple dual-port RAM, one write port, one registered read port.
// Latency: read data valid the cycle after rd_en. No backpressure.
// Ports: clk; wr_en/wr_addr/wr_dat write side; rd_en/rd_addr issue, rd_dat result.
module softmax_row_buf #(
   parameter int D_W    = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [D_W-1:0]    wr_dat,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [D_W-1:0]    rd_dat
);

   // No reset on the array or read register so the tools can map to block RAM.
   logic [D_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/softmax_max_sub.sv
// Row max-subtract: buffers one score row, finds its max, streams sat(x - max).
// Latency: first out_valid 3 cycles after the last accepted beat; len contiguous beats.
// Backpressure: in_ready low while draining; output side has none, enable stalls all.
// Ports: clk/rst (async high), enable; in_valid/in_ready/qin/row_len input beats;
//        out_valid/out_last/qout feed the exp stage directly.
module softmax_max_sub
   import softmax_pkg::*;
#(
   parameter int D_W     = SM_D_W,
   parameter int MAX_LEN = 128,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [D_W-1:0]  qin,
   input  logic [LEN_W-1:0]       row_len,
   output logic                   out_valid,
   output logic                   out_last,
   output logic signed [D_W-1:0]  qout
);

   localparam int               ADDR_W  = $clog2(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [ADDR_W-1:0]     wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0]     rd_cnt_q, rd_cnt_d;
   logic signed [D_W-1:0] max_q, max_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  rd_last_q, rd_last_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic signed [D_W-1:0] qout_q, qout_d;

   logic                  accept;
   logic [LEN_W-1:0]      len_in;
   logic [LEN_W-1:0]      len_m1;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic                  rd_en;
   logic                  rd_last;
   logic signed [D_W-1:0] rd_dat;

   assign in_ready  = enable && ((state_q == IDLE) || (state_q == LOAD));
   assign accept    = in_valid && in_ready;
   // Out-of-range lengths (0 or above the buffer depth) mean a full row.
   assign len_in    = ((row_len == '0) || (row_len > LEN_MAX)) ? LEN_MAX : row_len;
   assign len_m1    = len_q - LEN_W'(1);

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign qout      = qout_q;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      max_d    = max_q;
      wr_en    = 1'b0;
      wr_addr  = wr_cnt_q;
      rd_en    = 1'b0;
      rd_last  = 1'b0;

      case (state_q)
         IDLE: begin
            // The new row's max is only written here, after the previous row's
            // final read was issued, so its in-flight outputs still see the old max.
            if (accept) begin
               len_d   = len_in;
               max_d   = qin;
               wr_en   = 1'b1;
               wr_addr = '0;
               if (len_in == LEN_W'(1)) begin
                  state_d = DRAIN;
               end else begin
                  wr_cnt_d = ADDR_W'(1);
                  state_d  = LOAD;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               max_d = (qin > max_q) ? qin : max_q;
               if ({1'b0, wr_cnt_q} == len_m1) begin
                  wr_cnt_d = '0;
                  state_d  = DRAIN;
               end else begin
                  wr_cnt_d = wr_cnt_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            rd_en   = enable;
            rd_last = ({1'b0, rd_cnt_q} == len_m1);
            if (rd_last) begin
               rd_cnt_d = '0;
               state_d  = IDLE;
            end else begin
               rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Two-stage valid pipeline: RAM read register, then output register.
      rd_vld_d    = rd_en;
      rd_last_d   = rd_en && rd_last;
      out_valid_d = rd_vld_q;
      out_last_d  = rd_last_q;
      qout_d      = rd_vld_q ? sat_sub(rd_dat, max_q) : qout_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         max_q       <= '0;
         rd_vld_q    <= 1'b0;
         rd_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         qout_q      <= '0;
      end else if (enable) begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         max_q       <= max_d;
         rd_vld_q    <= rd_vld_d;
         rd_last_q   <= rd_last_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         qout_q      <= qout_d;
      end
   end

   softmax_row_buf #(
      .D_W   (D_W),
      .DEPTH (MAX_LEN)
   ) u_row_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_dat  (qin),
      .rd_en   (rd_en),
      .rd_addr (rd_cnt_q),
      .rd_dat  (rd_dat)
   );

endmodule

// File: tb/tb_softmax_max_sub.sv
module tb_softmax_max_sub;
   localparam int D_W     = 32;
   localparam int MAX_LEN = 128;
   localparam int LEN_W   = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  enable = 1'b1;
   logic                  in_valid = 1'b0;
   logic [LEN_W-1:0]      row_len = '0;
   logic signed [D_W-1:0] qin = '0;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_last;
   logic signed [D_W-1:0] qout;

   softmax_max_sub #(.D_W(D_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .qin       (qin),
      .row_len   (row_len),
      .out_valid (out_valid),
      .out_last  (out_last),
      .qout      (qout)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint val;
      bit     last;
   } exp_t;

   exp_t   exp_q[$];
   longint got_q[$];
   exp_t   e;
   int     tests = 0;
   int     errors = 0;
   int     cyc = 0;
   int     acc_cyc = 0;
   int     first_cyc = 0;
   bit     seen_first = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp_v);
      tests++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference model: each row's output is every element minus the row max,
   // clamped at the most negative D_W value.
   task automatic push_row(input int len_field, input longint vals[$]);
      int     eff;
      longint mx;
      longint d;
      longint lo;
      exp_t   x;
      lo  = -(longint'(1) <<< (D_W - 1));
      eff = (len_field == 0 || len_field > MAX_LEN) ? MAX_LEN : len_field;
      mx  = vals[0];
      for (int i = 1; i < eff; i++) if (vals[i] > mx) mx = vals[i];
      for (int i = 0; i < eff; i++) begin
         d = vals[i] - mx;
         if (d < lo) d = lo;
         x.val  = d;
         x.last = (i == eff - 1);
         exp_q.push_back(x);
      end
   endtask

   task automatic drive_beat(input int len_field, input longint v);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      qin      = D_W'(v);
      row_len  = LEN_W'(len_field);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("in_ready_timeout", 0, 1);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_row(input int len_field, input longint vals[$], input int gap);
      push_row(len_field, vals);
      foreach (vals[i]) begin
         drive_beat(len_field, vals[i]);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
      end
      if (!done) chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string name, input longint lit[$]);
      chk({name, "_count"}, got_q.size(), lit.size());
      for (int i = 0; i < lit.size(); i++) begin
         if (i < got_q.size()) chk(name, got_q[i], lit[i]);
      end
      got_q.delete();
   endtask

   // Compare process: a beat is consumed on every enabled cycle with out_valid.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !seen_first) begin
            seen_first = 1'b1;
            first_cyc  = cyc;
         end
         if (out_valid && enable) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("qout", longint'(qout), e.val);
               chk("out_last", longint'(out_last), longint'(e.last));
               got_q.push_back(longint'(qout));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint vals[$];
      longint lit[$];
      longint held;
      longint mn;
      longint mx;
      mn = -(longint'(1) <<< (D_W - 1));
      mx = (longint'(1) <<< (D_W - 1)) - 1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_qout", qout, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic row with latency and in_ready checks
      seen_first = 1'b0;
      send_row(4, '{3, -1, 7, 2}, 0);
      repeat (4) begin
         @(negedge clk);
         chk("drain_in_ready", in_ready, 0);
      end
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      wait_drain();
      chk("first_latency", first_cyc - acc_cyc, 3);
      check_got("basic", '{-4, -8, 0, -5});

      // Negative saturation
      vals.delete();
      vals.push_back(mn);
      vals.push_back(mx);
      send_row(2, vals, 0);
      wait_drain();
      lit.delete();
      lit.push_back(mn);
      lit.push_back(0);
      check_got("sat", lit);

      // Length one
      send_row(1, '{5}, 0);
      wait_drain();
      check_got("len1", '{0});

      // Length zero means a full row
      vals.delete();
      lit.delete();
      for (int i = 0; i < MAX_LEN; i++) begin
         vals.push_back(-77);
         lit.push_back(0);
      end
      send_row(0, vals, 0);
      wait_drain();
      check_got("len0", lit);

      // Gappy input
      send_row(5, '{4, -9, 12, 12, -3}, 2);
      wait_drain();
      check_got("gappy", '{-8, -21, 0, 0, -15});

      // Stall during drain
      send_row(4, '{3, -1, 7, 2}, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      held   = longint'(qout);
      repeat (5) begin
         @(negedge clk);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_qout", longint'(qout), held);
      end
      @(posedge clk);
      #1;
      enable = 1'b1;
      wait_drain();
      check_got("stall", '{-4, -8, 0, -5});

      // Asynchronous reset mid-row
      drive_beat(4, 10);
      drive_beat(4, 20);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_qout", longint'(qout), 0);
      chk("arst_in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      got_q.delete();
      send_row(2, '{1, 2}, 0);
      wait_drain();
      check_got("after_rst", '{-1, 0});

      // Back-to-back rows
      send_row(3, '{0, 0, 9}, 0);
      send_row(2, '{-5, -3}, 0);
      wait_drain();
      check_got("b2b", '{-9, -9, 0, -2, 0});

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
